// File: rtl/regfile_sb.sv
// Register file with an issue scoreboard.
// Two combinational read ports and one write port. A pending bit per register
// tracks outstanding results. All state updates on the falling edge of clk_n.
module regfile_sb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter bit ZERO_R0 = 1'b0,
    parameter bit BYPASS  = 1'b1
) (
    input  logic              clk_n,
    input  logic              rst_n,
    input  logic              WE,
    input  logic [ADDR_W-1:0] Waddr,
    input  logic [DATA_W-1:0] Wdata,
    input  logic [ADDR_W-1:0] Aaddr,
    input  logic [ADDR_W-1:0] Baddr,
    output logic [DATA_W-1:0] Adata,
    output logic [DATA_W-1:0] Bdata,
    input  logic              ISS,
    input  logic [ADDR_W-1:0] ISSaddr,
    output logic              Aready,
    output logic              Bready,
    output logic [ADDR_W:0]   Pcnt,
    output logic              Full
);

    localparam int DEPTH = 2 ** ADDR_W;
    // With a hardwired r0 only DEPTH-1 registers can ever be pending.
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(ZERO_R0 ? DEPTH - 1 : DEPTH);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   pcnt_q, pcnt_d;
    logic              we_ok, iss_ok, we_clears;

    // Qualify write/issue: r0 is untouchable when hardwired, and a full
    // scoreboard only accepts an issue when the same edge frees a slot.
    always_comb begin
        we_ok     = WE && !(ZERO_R0 && (Waddr == '0));
        we_clears = we_ok && pend_q[Waddr];
        iss_ok    = ISS && !(ZERO_R0 && (ISSaddr == '0)) && (!Full || we_clears);
    end

    // Next pending set (issue applied after clear so issue wins) and its population.
    always_comb begin
        pend_d = pend_q;
        if (we_ok) begin
            pend_d[Waddr] = 1'b0;
        end
        if (iss_ok) begin
            pend_d[ISSaddr] = 1'b1;
        end
        pcnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pcnt_d = pcnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
        end
    end

    // Register array, scoreboard and count update on the falling clock edge.
    always_ff @(negedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
            pcnt_q <= '0;
        end else begin
            if (we_ok) begin
                regs_q[Waddr] <= Wdata;
            end
            pend_q <= pend_d;
            pcnt_q <= pcnt_d;
        end
    end

    // Read port A: hardwired r0, then bypass, then array; forced to 0 in reset.
    always_comb begin
        Adata = regs_q[Aaddr];
        if (BYPASS && we_ok && (Waddr == Aaddr)) begin
            Adata = Wdata;
        end
        if ((ZERO_R0 && (Aaddr == '0)) || !rst_n) begin
            Adata = '0;
        end
    end

    // Read port B: same selection as port A.
    always_comb begin
        Bdata = regs_q[Baddr];
        if (BYPASS && we_ok && (Waddr == Baddr)) begin
            Bdata = Wdata;
        end
        if ((ZERO_R0 && (Baddr == '0)) || !rst_n) begin
            Bdata = '0;
        end
    end

    // Readiness: not pending, or satisfied by a bypassed write that is not re-issued.
    always_comb begin
        Aready = !pend_q[Aaddr] ||
                 (BYPASS && we_ok && (Waddr == Aaddr) && !(ISS && (ISSaddr == Aaddr)));
        Bready = !pend_q[Baddr] ||
                 (BYPASS && we_ok && (Waddr == Baddr) && !(ISS && (ISSaddr == Baddr)));
        if (!rst_n) begin
            Aready = 1'b1;
            Bready = 1'b1;
        end
    end

    assign Pcnt = pcnt_q;
    assign Full = (pcnt_q == FULL_CNT);

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, 16, register data width in bits; SHALL support 8..64.
REQ-002 Parameter ADDR_W, 3, register address width; depth SHALL be 2**ADDR_W.
REQ-003 Parameter ZERO_R0, 0, when 1 register 0 SHALL be hardwired to zero and never pending.
REQ-004 Parameter BYPASS, 1, when 1 write data SHALL be forwarded combinationally to matching read ports.
REQ-005 clk_n  input  1  clock; all state SHALL update on the falling edge of clk_n.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 WE  input  1  write enable.
REQ-008 Waddr  input  ADDR_W  write address.
REQ-009 Wdata  input  DATA_W  write data.
REQ-010 Aaddr  input  ADDR_W  read port A address.
REQ-011 Baddr  input  ADDR_W  read port B address.
REQ-012 Adata  output  DATA_W  read port A data, combinational.
REQ-013 Bdata  output  DATA_W  read port B data, combinational.
REQ-014 ISS  input  1  issue strobe; marks register ISSaddr pending.
REQ-015 ISSaddr  input  ADDR_W  register whose result is outstanding.
REQ-016 Aready  output  1  high when register Aaddr is not pending (or bypass satisfies it).
REQ-017 Bready  output  1  same for Baddr.
REQ-018 Pcnt  output  ADDR_W+1  number of pending registers.
REQ-019 Full  output  1  high when Pcnt equals depth (ZERO_R0=1: depth-1).

Function
REQ-020 Write: on falling clk_n with WE=1, reg[Waddr] SHALL take Wdata; WE=0 SHALL leave all registers unchanged.
REQ-021 Read: Adata/Bdata SHALL equal reg[Aaddr]/reg[Baddr] with no clock latency.
REQ-022 BYPASS=1 and WE=1 and Waddr==Aaddr: Adata SHALL equal Wdata in the same cycle; likewise port B.
REQ-023 BYPASS=0: read of the address being written SHALL return the old value until the falling edge.
REQ-024 ZERO_R0=1: writes to address 0 SHALL be ignored, reads of address 0 SHALL return 0, bypass SHALL not apply to address 0, ISS to address 0 SHALL be ignored.
REQ-025 Scoreboard: one pending bit per register; ISS=1 SHALL set pend[ISSaddr] on the falling edge.
REQ-026 WE=1 SHALL clear pend[Waddr] on the falling edge.
REQ-027 Simultaneous ISS and WE to the same address: pending SHALL remain set (issue wins); register data SHALL still be written.
REQ-028 Simultaneous ISS and WE to different addresses: both updates SHALL occur.
REQ-029 ISS to an already-pending register SHALL leave it pending; Pcnt SHALL not double count.
REQ-030 WE to a non-pending register SHALL write data and leave Pcnt unchanged.
REQ-031 Aready = ~pend[Aaddr], or 1 when BYPASS=1 and WE=1 and Waddr==Aaddr and the address is not simultaneously issued; likewise Bready.
REQ-032 Pcnt SHALL be a registered count equal to the population of pend after each edge; SHALL never wrap.
REQ-033 ISS while Full=1 SHALL be ignored unless the same edge's WE clears a pending bit.
REQ-034 Undriven (X) addresses with WE=0 and ISS=0 SHALL not alter state.

Reset
REQ-035 rst_n low SHALL immediately clear all registers to 0, all pending bits to 0, Pcnt to 0, Full to 0.
REQ-036 With rst_n low, Adata/Bdata SHALL read 0 (bypass SHALL be suppressed) and Aready/Bready SHALL be 1.
REQ-037 Reset asserted mid-cycle SHALL discard any write or issue of that cycle; release SHALL take effect at the next falling edge.

Verification
REQ-038 Defaults: write 0x1111,0x2222,0x4444,0x8888,0x9999,0xAAAA,0xCCCC,0xDDDD to r0..r7 -> each readback on A and B matches next cycle.
REQ-039 Bypass: WE=1, Waddr=3, Wdata=0xEEEE, Aaddr=3 before the edge -> Adata=0xEEEE same cycle; with BYPASS=0 -> old value 0x8888.
REQ-040 Scoreboard: ISS r2, r5 -> Pcnt=2, Aready=0 for Aaddr=2; WE r2 -> Pcnt=1, Aready=1; ISS and WE r5 same edge -> r5 pending, data updated.
REQ-041 Full: issue all 8 registers -> Full=1, Pcnt=8; further ISS ignored; WE r0 with ISS r0 -> Full stays 1.
REQ-042 ZERO_R0=1: write 0xFFFF to r0 -> Adata=0 at Aaddr=0; ISS r0 -> Pcnt unchanged; Full at Pcnt=7.
REQ-043 Reset mid-operation: rst_n low between edges after loading data and pending -> all reads 0, Pcnt=0, Ready=1 without waiting for clock.
